muldiv_unit: RTL and testbench

//   Parametrised iterative multiply/divide unit for the MIPS150 datapath; the

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the issuing pipeline stage and muldiv_unit.
// No latency of its own; flow control is start/busy/done, carried as plain signals.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU into HI/LO; signed ops need MULDIV_SIGNED_EN.
// Latency: fixed WIDTH+2 cycles from the start cycle to the one-cycle done pulse.
// Backpressure: busy high in RUN/FIX, start ignored then; start in the done cycle launches at once.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  io
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t             state, state_nxt;
   logic               launch;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc, q_reg, b_mag, a_lat;
   logic               is_div, b_zero, neg_q, neg_r;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               dbz_q;

   logic               sgn, a_neg_in, b_neg_in;
   logic [WIDTH-1:0]   a_mag_in, b_mag_in;

`ifdef MULDIV_SIGNED_EN
   assign sgn = io.op[1];
`else
   logic unused_op_sign;
   assign unused_op_sign = io.op[1];
   assign sgn            = 1'b0;
`endif

   assign a_neg_in = sgn & io.a[WIDTH-1];
   assign b_neg_in = sgn & io.b[WIDTH-1];
   assign a_mag_in = a_neg_in ? -io.a : io.a;
   assign b_mag_in = b_neg_in ? -io.b : io.b;

   // One shift-add or restoring-subtract step; q_reg holds multiplier/dividend bits.
   logic [WIDTH:0]   mul_sum, div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_acc;

   assign mul_sum   = {1'b0, acc} + {1'b0, (q_reg[0] ? b_mag : {WIDTH{1'b0}})};
   assign div_shift = {acc, q_reg[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, b_mag};
   assign div_acc   = div_ge ? (div_shift[WIDTH-1:0] - b_mag) : div_shift[WIDTH-1:0];

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   always_comb begin
      prod   = {acc, q_reg};
      fix_hi = '0;
      fix_lo = '0;
      if (neg_q) prod = -prod;
      if (b_zero) begin
         fix_hi = a_lat;
         fix_lo = '1;
      end else if (is_div) begin
         fix_hi = neg_r ? -acc : acc;
         fix_lo = neg_q ? -q_reg : q_reg;
      end else begin
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      io.busy   = 1'b0;
      io.done   = 1'b0;
      case (state)
         S_IDLE: begin
            if (io.start) begin
               launch    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            io.busy = 1'b1;
            if (cnt == LAST_STEP) state_nxt = S_FIX;
         end
         S_FIX: begin
            io.busy   = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            io.done = 1'b1;
            if (io.start) begin
               launch    = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         q_reg  <= '0;
         b_mag  <= '0;
         a_lat  <= '0;
         is_div <= 1'b0;
         b_zero <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         dbz_q  <= 1'b0;
      end else if (launch) begin
         cnt    <= '0;
         acc    <= '0;
         q_reg  <= a_mag_in;
         b_mag  <= b_mag_in;
         a_lat  <= io.a;
         is_div <= io.op[0];
         b_zero <= io.op[0] & (io.b == '0);
         neg_q  <= a_neg_in ^ b_neg_in;
         neg_r  <= a_neg_in;
      end else if (state == S_RUN) begin
         cnt <= cnt + CNT_W'(1);
         if (is_div) begin
            acc   <= div_acc;
            q_reg <= {q_reg[WIDTH-2:0], div_ge};
         end else begin
            acc   <= mul_sum[WIDTH:1];
            q_reg <= {mul_sum[0], q_reg[WIDTH-1:1]};
         end
      end else if (state == S_FIX) begin
         hi_q  <= fix_hi;
         lo_q  <= fix_lo;
         dbz_q <= b_zero;
      end
   end

   assign io.hi          = hi_q;
   assign io.lo          = lo_q;
   assign io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors queued at issue, checked on done.
module tb_muldiv_unit;
   localparam int W = 32;
   localparam logic [1:0] OP_MULTU = 2'b00, OP_DIVU = 2'b01, OP_MULT = 2'b10, OP_DIV = 2'b11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) bus ();
   muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .io(bus));

   typedef struct {
      string          name;
      logic [W-1:0]   hi;
      logic [W-1:0]   lo;
      logic           dbz;
      int             cyc;
   } exp_t;

   exp_t sb[$];
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"},  bus.hi, e.hi);
            chk({e.name, "_lo"},  bus.lo, e.lo);
            chk({e.name, "_dbz"}, bus.div_by_zero, e.dbz);
            chk({e.name, "_lat"}, cyc, e.cyc);
         end
      end
   end

   // Called at a negedge; returns at the next negedge with operands scrambled.
   task automatic issue(string name, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                        logic [W-1:0] ehi, logic [W-1:0] elo, logic edbz, bit push);
      exp_t e;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      if (push) begin
         e.name = name;
         e.hi   = ehi;
         e.lo   = elo;
         e.dbz  = edbz;
         e.cyc  = cyc + W + 2;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.op    = 2'($urandom);
   endtask

   // Returns at the negedge of the done cycle, or flags a timeout.
   task automatic wait_done(string name, output int busy_n);
      bit seen;
      seen   = 1'b0;
      busy_n = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy === 1'b1) busy_n++;
         @(negedge clk);
      end
      if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic run(string name, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                      logic [W-1:0] ehi, logic [W-1:0] elo, logic edbz);
      int bn;
      issue(name, op, a, b, ehi, elo, edbz, 1'b1);
      wait_done(name, bn);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog sim_time_exceeded actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int bn;
      int done_cnt;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_hi",   bus.hi, 0);
      chk("rst_lo",   bus.lo, 0);
      chk("rst_dbz",  bus.div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      issue("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
      wait_done("multu_max", bn);
      chk("multu_max_busy_cycles", bn, W + 1);

      run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      issue("divu_7_100", OP_DIVU, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
      wait_done("divu_7_100", bn);
      chk("b2b_busy_cycles", bn, W + 1);

`ifdef MULDIV_SIGNED_EN
      run("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run("mult_min",   OP_MULT, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      run("div_min",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      run("mult_m3_5",  OP_MULT, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      run("div_7_m2",   OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
`else
      run("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0);
      run("mult_min",   OP_MULT, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 1'b0);
      run("div_min",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
      run("mult_m3_5",  OP_MULT, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 1'b0);
      run("div_7_m2",   OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000007, 32'h00000000, 1'b0);
`endif

      run("divu_by0", OP_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1);
      run("multu_after_dbz", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

      // A start pulse mid-operation must not disturb the running multiply.
      issue("multu_3_5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
      repeat (8) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.a     = 32'd77;
      bus.b     = 32'd9;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("multu_3_5", bn);
      @(negedge clk);

      // Reset mid-operation aborts with cleared outputs and no done.
      issue("abort", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (18) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_hi",   bus.hi, 0);
      chk("abort_lo",   bus.lo, 0);
      @(negedge clk);
      rst      = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
